// File: rtl/aline_fire_sequencer.sv
// A-line transmit sequencer: fetches per-channel delays for the current A-line,
// snapshots the configuration, then plays pulse_shape on each enabled channel
// offset by that channel's delay.
module aline_fire_sequencer #(
  parameter int unsigned NUM_CH  = 8,
  parameter int unsigned DELAY_W = 16,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned SHAPE_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      trigger,
  input  logic                      intaking_configs,
  input  logic [NUM_CH-1:0]         channel_select,
  input  logic [ADDR_W-1:0]         aline_select,
  input  logic [SHAPE_W-1:0]        pulse_shape,
  input  logic [NUM_CH*DELAY_W-1:0] delay_data,
  output logic [ADDR_W-1:0]         rd_addr,
  output logic [NUM_CH-1:0]         pulse_out,
  output logic [ADDR_W-1:0]         which_aline,
  output logic                      busy,
  output logic                      aline_done,
  output logic                      trig_missed
);

  // One extra bit so t can reach max delay + SHAPE_W without wrapping.
  localparam int unsigned TW = DELAY_W + 1;
  localparam logic [TW-1:0] ShapeLen = TW'(SHAPE_W);

  typedef enum logic [2:0] {StIdle, StFetch, StLatch, StFire, StDone} state_e;

  state_e                    state_q, state_d;
  logic [TW-1:0]             t_q, t_d;
  logic [ADDR_W-1:0]         rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0]         which_q, which_d;
  logic [NUM_CH-1:0]         pulse_q, pulse_d;
  logic [NUM_CH-1:0]         mask_q, mask_d;
  logic [SHAPE_W-1:0]        shape_q, shape_d;
  logic [NUM_CH*DELAY_W-1:0] dly_q, dly_d;
  logic [DELAY_W-1:0]        maxd_q, maxd_d;
  logic                      missed_q, missed_d;

  logic [NUM_CH-1:0]         sel_mask;
  logic [SHAPE_W-1:0]        sel_shape;
  logic [NUM_CH*DELAY_W-1:0] sel_dly;
  logic [TW-1:0]             t_next;
  logic [NUM_CH-1:0]         bits_next;
  logic [DELAY_W-1:0]        latch_maxd;
  logic [TW-1:0]             end_t;

  // Bit-generator sources: the first FIRE cycle is computed during LATCH from the live
  // inputs being snapshotted; every later cycle uses the snapshot.
  always_comb begin
    if (state_q == StLatch) begin
      sel_mask  = channel_select;
      sel_shape = pulse_shape;
      sel_dly   = delay_data;
      t_next    = '0;
    end else begin
      sel_mask  = mask_q;
      sel_shape = shape_q;
      sel_dly   = dly_q;
      t_next    = t_q + 1'b1;
    end
  end

  // Largest delay among enabled channels, captured with the snapshot.
  always_comb begin
    latch_maxd = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (channel_select[i] && (delay_data[i*DELAY_W +: DELAY_W] > latch_maxd)) begin
        latch_maxd = delay_data[i*DELAY_W +: DELAY_W];
      end
    end
  end

  // Per-channel transmit bit for time t_next: shape[SHAPE_W-1-(t-d)] inside the window.
  always_comb begin
    bits_next = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      logic [TW-1:0]      d_ext;
      logic [TW-1:0]      k;
      logic [SHAPE_W-1:0] sh;
      d_ext = {1'b0, sel_dly[i*DELAY_W +: DELAY_W]};
      k     = t_next - d_ext;
      sh    = sel_shape << k;
      if (sel_mask[i] && (t_next >= d_ext) && (k < ShapeLen)) begin
        bits_next[i] = sh[SHAPE_W-1];
      end
    end
  end

  assign end_t = {1'b0, maxd_q} + ShapeLen;

  // Next-state and register updates for the fire FSM.
  always_comb begin
    state_d   = state_q;
    t_d       = t_q;
    rd_addr_d = rd_addr_q;
    which_d   = which_q;
    pulse_d   = '0;
    mask_d    = mask_q;
    shape_d   = shape_q;
    dly_d     = dly_q;
    maxd_d    = maxd_q;
    missed_d  = trigger && (intaking_configs || (state_q != StIdle));

    unique case (state_q)
      StIdle: begin
        if (trigger && !intaking_configs) begin
          state_d   = StFetch;
          rd_addr_d = which_q;
        end
      end
      StFetch: begin
        if (intaking_configs) begin
          state_d = StIdle;
          which_d = '0;
        end else begin
          state_d = StLatch;
        end
      end
      StLatch: begin
        if (intaking_configs) begin
          state_d = StIdle;
          which_d = '0;
        end else begin
          mask_d  = channel_select;
          shape_d = pulse_shape;
          dly_d   = delay_data;
          maxd_d  = latch_maxd;
          t_d     = '0;
          if (channel_select == '0) begin
            state_d = StDone;
          end else begin
            state_d = StFire;
            pulse_d = bits_next;
          end
        end
      end
      StFire: begin
        if (intaking_configs) begin
          state_d = StIdle;
          which_d = '0;
        end else if (t_next == end_t) begin
          state_d = StDone;
        end else begin
          t_d     = t_next;
          pulse_d = bits_next;
        end
      end
      StDone: begin
        state_d = StIdle;
        t_d     = '0;
        which_d = (which_q >= aline_select) ? '0 : which_q + 1'b1;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      t_q       <= '0;
      rd_addr_q <= '0;
      which_q   <= '0;
      pulse_q   <= '0;
      mask_q    <= '0;
      shape_q   <= '0;
      dly_q     <= '0;
      maxd_q    <= '0;
      missed_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      rd_addr_q <= rd_addr_d;
      which_q   <= which_d;
      pulse_q   <= pulse_d;
      mask_q    <= mask_d;
      shape_q   <= shape_d;
      dly_q     <= dly_d;
      maxd_q    <= maxd_d;
      missed_q  <= missed_d;
    end
  end

  assign rd_addr     = rd_addr_q;
  assign pulse_out   = pulse_q;
  assign which_aline = which_q;
  assign busy        = (state_q != StIdle);
  assign aline_done  = (state_q == StDone);
  assign trig_missed = missed_q;

endmodule

// File: tb/tb_aline_fire_sequencer.sv
// Scoreboard bench for aline_fire_sequencer: each accepted trigger pushes the expected
// pulse words, completion cycle and next A-line index; a negedge monitor pops and compares.
module tb_aline_fire_sequencer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         trigger = 1'b0;
  logic         intaking = 1'b0;
  logic [7:0]   chsel = '0;
  logic [4:0]   asel = '0;
  logic [31:0]  shape = '0;
  logic [127:0] ddata;
  logic [4:0]   rd_addr;
  logic [7:0]   pout;
  logic [4:0]   which;
  logic         busy;
  logic         done;
  logic         missed;

  logic [127:0] mem [32];

  aline_fire_sequencer #(
    .NUM_CH (8),
    .DELAY_W(16),
    .ADDR_W (5),
    .SHAPE_W(32)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .trigger         (trigger),
    .intaking_configs(intaking),
    .channel_select  (chsel),
    .aline_select    (asel),
    .pulse_shape     (shape),
    .delay_data      (ddata),
    .rd_addr         (rd_addr),
    .pulse_out       (pout),
    .which_aline     (which),
    .busy            (busy),
    .aline_done      (done),
    .trig_missed     (missed)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Delay storage with one cycle of read latency.
  always @(posedge clk) ddata <= mem[rd_addr];

  typedef struct {int cyc; logic [7:0] w;} pev_t;
  typedef struct {int cyc; logic [4:0] nxt;} dev_t;
  pev_t pq[$];
  dev_t dq[$];
  int   mq[$];

  int         n_chk = 0;
  int         n_bad = 0;
  logic [4:0] mdl_aline = '0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Monitor: every cycle, pulse_out / aline_done / trig_missed against the scoreboard.
  initial begin
    logic       chk_which;
    logic [4:0] which_exp;
    chk_which = 1'b0;
    which_exp = '0;
    forever begin
      logic [7:0] ep;
      logic       ed;
      logic       em;
      pev_t       pe;
      dev_t       de;
      @(negedge clk);
      ep = '0;
      if (pq.size() > 0 && pq[0].cyc == cyc) begin
        pe = pq.pop_front();
        ep = pe.w;
      end
      check_eq("pulse_out", pout, ep);
      if (chk_which) begin
        check_eq("which_aline", which, which_exp);
        chk_which = 1'b0;
      end
      ed = (dq.size() > 0) && (dq[0].cyc == cyc);
      check_eq("aline_done", done, ed);
      if (ed) begin
        de        = dq.pop_front();
        which_exp = de.nxt;
        chk_which = 1'b1;
      end
      em = (mq.size() > 0) && (mq[0] == cyc);
      check_eq("trig_missed", missed, em);
      if (em) void'(mq.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  function automatic logic [7:0] exp_word(input logic [127:0] dl, input logic [7:0] m,
                                          input logic [31:0] s, input int t);
    logic [7:0] w;
    w = '0;
    for (int ch = 0; ch < 8; ch++) begin
      int d;
      d = int'(dl[ch*16 +: 16]);
      if (m[ch] && t >= d && (t - d) < 32) w[ch] = s[31 - (t - d)];
    end
    return w;
  endfunction

  // Drive an accepted trigger and record everything it should produce.
  task automatic fire();
    int         c;
    int         maxd;
    int         endt;
    logic [4:0] a;
    logic [4:0] nxt;
    dev_t       de;
    c    = cyc;
    a    = mdl_aline;
    maxd = 0;
    trigger = 1'b1;
    for (int ch = 0; ch < 8; ch++) begin
      if (chsel[ch] && int'(mem[a][ch*16 +: 16]) > maxd) maxd = int'(mem[a][ch*16 +: 16]);
    end
    endt = (chsel == '0) ? 0 : maxd + 32;
    for (int t = 0; t < endt; t++) begin
      pev_t pe;
      pe.cyc = c + 3 + t;
      pe.w   = exp_word(mem[a], chsel, shape, t);
      if (pe.w != '0) pq.push_back(pe);
    end
    nxt    = (a >= asel) ? 5'd0 : a + 5'd1;
    de.cyc = c + 3 + endt;
    de.nxt = nxt;
    dq.push_back(de);
    mdl_aline = nxt;
    tick();
    trigger = 1'b0;
    check_eq("busy_fetch", busy, 1);
    check_eq("rd_addr", rd_addr, a);
    tick();
    tick();
  endtask

  // Trigger that must be ignored and answered by trig_missed one cycle later.
  task automatic poke();
    trigger = 1'b1;
    mq.push_back(cyc + 1);
    tick();
    trigger = 1'b0;
  endtask

  task automatic wait_idle();
    if (dq.size() > 0) run_to(dq[dq.size()-1].cyc + 2);
    check_eq("idle_after", busy, 0);
  endtask

  task automatic flush_pulses(input int from);
    pev_t keep[$];
    foreach (pq[i]) if (pq[i].cyc < from) keep.push_back(pq[i]);
    pq = keep;
  endtask

  initial begin
    int a;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_pulse", pout, 0);
    check_eq("rst_which", which, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_missed", missed, 0);
    check_eq("rst_rdaddr", rd_addr, 0);
    rst = 1'b0;
    tick();

    // Wrap of which_aline at aline_select=2 with zero delays.
    asel  = 5'd2;
    chsel = 8'h01;
    shape = 32'hA5A5_F00F;
    repeat (4) begin
      fire();
      wait_idle();
    end

    // Empty mask: straight to DONE.
    chsel = 8'h00;
    fire();
    wait_idle();

    // which_aline is 2: mixed delays, snapshot isolation, ignored triggers.
    mem[2]          = '0;
    mem[2][0 +: 16]  = 16'd3;
    mem[2][16 +: 16] = 16'd9;
    mem[2][32 +: 16] = 16'd10;
    chsel = 8'h05;
    shape = 32'hF0F0_1234;
    fire();
    chsel  = 8'hFF;
    shape  = 32'h0;
    mem[2] = '1;
    run_to(cyc + 7);
    poke();
    run_to(dq[dq.size()-1].cyc);
    poke();
    tick();
    intaking = 1'b1;
    poke();
    intaking = 1'b0;
    tick();
    check_eq("cfg_trig_idle", busy, 0);

    // Walk which_aline to 3, then abort at t=10.
    asel  = 5'd5;
    chsel = 8'h00;
    repeat (3) begin
      fire();
      wait_idle();
    end
    for (int ch = 0; ch < 8; ch++) mem[3][ch*16 +: 16] = 16'd2;
    chsel = 8'hFF;
    shape = 32'hFFFF_0000;
    fire();
    a = cyc - 3;
    run_to(a + 3 + 10);
    intaking = 1'b1;
    flush_pulses(cyc + 1);
    dq.delete();
    mdl_aline = '0;
    tick();
    check_eq("abort_which", which, 0);
    check_eq("abort_busy", busy, 0);
    tick();
    intaking = 1'b0;
    tick();

    // Reset at t=4, then the reference A-line must replay exactly.
    asel             = 5'd2;
    mem[0]           = '0;
    mem[0][0 +: 16]  = 16'd0;
    mem[0][16 +: 16] = 16'd5;
    mem[0][32 +: 16] = 16'd7;
    chsel = 8'h03;
    shape = 32'h8000_0001;
    fire();
    a = cyc - 3;
    run_to(a + 3 + 4);
    rst = 1'b1;
    flush_pulses(cyc);
    dq.delete();
    mdl_aline = '0;
    #1;
    check_eq("midrst_pulse", pout, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_which", which, 0);
    check_eq("midrst_rdaddr", rd_addr, 0);
    tick();
    rst = 1'b0;
    tick();
    fire();
    wait_idle();

    check_eq("sb_pulse_left", pq.size(), 0);
    check_eq("sb_done_left", dq.size(), 0);
    check_eq("sb_miss_left", mq.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: got timeout want completion");
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
